// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY definitions for the parallel-to-serial transmit stage:
// default line symbols and the SYNC/ACTIVE state encoding.
package phy_pkg;

  // Comma / training symbol
  localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
  // Idle filler symbol
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

  // Transmitter phase: comma training first, then payload/idle
  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } ps_state_t;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Byte handshake and serial line between the upstream 2:1 byte mux
// (master) and the serializer (slave).
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       load_tick;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  load_tick,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output load_tick,
    output active
  );
endinterface

// File: rtl/paralelo_serial_tx_shift8.sv
// ps_shift8: 8-cycle bit counter and MSB-first shift register.
// A new byte is loaded on the edge where bit_cnt==7; bit 7 of that byte
// is on data_out during the following cycle.
module ps_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] next_byte,
  input  logic       active,
  output logic       load_edge,
  output logic       data_out,
  output logic       load_tick
);

  logic [2:0] bit_cnt_r;
  logic [7:0] shreg_r;

  // Bit counter and shift register; reset parks bit_cnt at 7 so the
  // first edge after release loads a byte.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      bit_cnt_r <= 3'd7;
      shreg_r   <= 8'h00;
    end else begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        shreg_r <= next_byte;
      end else begin
        shreg_r <= {shreg_r[6:0], 1'b0};
      end
    end
  end

  assign load_edge = (bit_cnt_r == 3'd7);
  assign data_out  = shreg_r[7];
  // Upstream is told its byte is consumed only once training is over
  assign load_tick = load_edge & active;

endmodule

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: final transmit stage of the PHY lane.
// After reset sends SYNC_BYTES comma bytes, then payload bytes or IDLE.
// Optional feature macro: PS_COM_INSERT_EN -- forces one COM after
// COM_PERIOD-1 consecutive idle bytes.
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int         SYNC_BYTES = 4,
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF
`ifdef PS_COM_INSERT_EN
  , parameter int       COM_PERIOD = 16
`endif
) (
  input  logic                clk_32f,
  input  logic                reset,
  paralelo_serial_tx_if.slave bus
);

  localparam int SC_W = $clog2(SYNC_BYTES) + 1;

  ps_state_t       state_r, state_next_s;
  logic [SC_W-1:0] sync_cnt_r, sync_cnt_next_s;
  logic [7:0]      next_byte_s;
  logic            load_edge_s;
  logic            active_s;

`ifdef PS_COM_INSERT_EN
  localparam int IC_W = $clog2(COM_PERIOD) + 1;
  logic [IC_W-1:0] idle_cnt_r, idle_cnt_next_s;

  // Idle run counter: length of the current run of idle bytes
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_next_s;
    end
  end
`endif

  // Training state and comma counter
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_r    <= SYNC;
      sync_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      sync_cnt_r <= sync_cnt_next_s;
    end
  end

  // Next-state and next-byte selection
  always_comb begin
    state_next_s    = state_r;
    sync_cnt_next_s = sync_cnt_r;
    next_byte_s     = COM_SYM;
`ifdef PS_COM_INSERT_EN
    idle_cnt_next_s = idle_cnt_r;
`endif
    case (state_r)
      SYNC: begin
        next_byte_s = COM_SYM;
        if (load_edge_s) begin
          sync_cnt_next_s = sync_cnt_r + SC_W'(1);
          if (sync_cnt_r == SC_W'(SYNC_BYTES - 1)) begin
            state_next_s = ACTIVE;
          end else begin
            state_next_s = SYNC;
          end
        end else begin
          state_next_s = SYNC;
        end
      end
      ACTIVE: begin
        state_next_s = ACTIVE;
        if (bus.valid_in) begin
          next_byte_s = bus.data_in;
`ifdef PS_COM_INSERT_EN
          if (load_edge_s) begin
            idle_cnt_next_s = '0;
          end else begin
            idle_cnt_next_s = idle_cnt_r;
          end
        end else if (idle_cnt_r == IC_W'(COM_PERIOD - 1)) begin
          next_byte_s = COM_SYM;
          if (load_edge_s) begin
            idle_cnt_next_s = '0;
          end else begin
            idle_cnt_next_s = idle_cnt_r;
          end
`endif
        end else begin
          next_byte_s = IDLE_SYM;
`ifdef PS_COM_INSERT_EN
          if (load_edge_s) begin
            idle_cnt_next_s = idle_cnt_r + IC_W'(1);
          end else begin
            idle_cnt_next_s = idle_cnt_r;
          end
`endif
        end
      end
      default: begin
        state_next_s = SYNC;
        next_byte_s  = COM_SYM;
      end
    endcase
  end

  assign active_s   = (state_r == ACTIVE);
  assign bus.active = active_s;

  ps_shift8 u_shift (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .next_byte (next_byte_s),
    .active    (active_s),
    .load_edge (load_edge_s),
    .data_out  (bus.data_out),
    .load_tick (bus.load_tick)
  );

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: a timeline model (byte j is
// loaded on edge 8j+1 after reset release) predicts data_out, load_tick and
// active every cycle; directed captures pin the model to literal bytes.
module tb_paralelo_serial_tx;

  localparam int SYNC_BYTES = 4;
  localparam int COM_PERIOD = 16;
`ifdef PS_COM_INSERT_EN
  localparam bit COM_INSERT = 1'b1;
`else
  localparam bit COM_INSERT = 1'b0;
`endif

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  paralelo_serial_tx_if bus ();

  paralelo_serial_tx #(.SYNC_BYTES(SYNC_BYTES)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: edges since reset release and the byte currently being shifted
  int         m_edges = 0;
  logic [7:0] m_byte  = 8'h00;
  int         m_idle  = 0;

  always @(posedge clk_32f) begin
    if (!reset) begin
      m_edges <= 0;
      m_byte  <= 8'h00;
      m_idle  <= 0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_edges % 8 == 0) begin
        if (m_edges / 8 < SYNC_BYTES) begin
          m_byte <= 8'hBC;
        end else if (bus.valid_in) begin
          m_byte <= bus.data_in;
          m_idle <= 0;
        end else if (COM_INSERT && m_idle == COM_PERIOD - 1) begin
          m_byte <= 8'hBC;
          m_idle <= 0;
        end else begin
          m_byte <= 8'h7C;
          m_idle <= m_idle + 1;
        end
      end
    end
  end

  logic exp_d, exp_a, exp_t;

  // Per-cycle comparison against the model
  always @(negedge clk_32f) begin
    if (chk_en) begin
      exp_d = (m_edges == 0) ? 1'b0 : m_byte[7 - ((m_edges - 1) % 8)];
      exp_a = (m_edges > 8 * (SYNC_BYTES - 1));
      exp_t = exp_a && (m_edges % 8 == 0) && (m_edges / 8 >= SYNC_BYTES);
      check("data_out", {31'd0, bus.data_out}, {31'd0, exp_d});
      check("active", {31'd0, bus.active}, {31'd0, exp_a});
      check("load_tick", {31'd0, bus.load_tick}, {31'd0, exp_t});
    end
  end

  task automatic wait_tick();
    int i = 0;
    while (!bus.load_tick && i < 20) begin
      @(negedge clk_32f);
      i++;
    end
    if (!bus.load_tick) begin
      n_checks++;
      $display("FAIL tick_timeout: load_tick low for %0d cycles, required high", i);
    end
  endtask

  // Offer one byte at load_tick and capture the 8 serial bits it produces
  task automatic xfer(input logic v, input logic [7:0] d, output logic [7:0] got);
    wait_tick();
    bus.valid_in = v;
    bus.data_in  = d;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_32f);
      got = {got[6:0], bus.data_out};
      if (i == 0) bus.valid_in = 1'b0;
    end
  endtask

  task automatic capture_sync(input string name);
    logic [31:0] got32 = 32'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_32f);
      got32 = {got32[30:0], bus.data_out};
      if (i == 23) check({name, "_active_pre"}, {31'd0, bus.active}, 32'd0);
      if (i == 24) check({name, "_active_post"}, {31'd0, bus.active}, 32'd1);
    end
    check(name, got32, 32'hBCBCBCBC);
    check({name, "_first_tick"}, {31'd0, bus.load_tick}, 32'd1);
  endtask

  logic [7:0] got;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    reset        = 1'b0;
    @(posedge clk_32f);
    chk_en = 1'b1;
    repeat (10) @(negedge clk_32f);
    check("reset_data_out", {31'd0, bus.data_out}, 32'd0);
    reset = 1'b1;

    capture_sync("sync_seq");

    xfer(1'b1, 8'hA5, got);
    check("byte_a5", {24'd0, got}, 32'h000000A5);
    xfer(1'b0, 8'h00, got);
    check("idle_after_a5", {24'd0, got}, 32'h0000007C);

    // valid pulse that ends before load_tick must not be consumed
    wait_tick();
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h55;
    repeat (2) @(negedge clk_32f);
    bus.valid_in = 1'b0;
    xfer(1'b0, 8'h55, got);
    check("midbyte_valid_ignored", {24'd0, got}, 32'h0000007C);

    // Randomized traffic with garbage between load_ticks
    for (int b = 0; b < 60; b++) begin
      wait_tick();
      bus.valid_in = ($urandom_range(3) == 0);
      bus.data_in  = 8'($urandom);
      @(negedge clk_32f);
      for (int k = 0; k < 6; k++) begin
        bus.valid_in = 1'($urandom);
        bus.data_in  = 8'($urandom);
        @(negedge clk_32f);
      end
      bus.valid_in = 1'b0;
    end

`ifdef PS_COM_INSERT_EN
    xfer(1'b1, 8'h3C, got);
    check("byte_3c", {24'd0, got}, 32'h0000003C);
    for (int k = 0; k < 16; k++) begin
      xfer(1'b0, 8'h00, got);
      check("idle_run", {24'd0, got}, (k == 15) ? 32'h000000BC : 32'h0000007C);
    end
`endif

    // Reset in the middle of an 0xFF byte
    wait_tick();
    bus.valid_in = 1'b1;
    bus.data_in  = 8'hFF;
    @(negedge clk_32f);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    check("ff_midbyte", {31'd0, bus.data_out}, 32'd1);
    reset = 1'b0;
    @(negedge clk_32f);
    check("reset_mid_byte", {31'd0, bus.data_out}, 32'd0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    capture_sync("resync_seq");

    xfer(1'b1, 8'hC3, got);
    check("byte_c3", {24'd0, got}, 32'h000000C3);
    xfer(1'b0, 8'h00, got);
    check("idle_after_c3", {24'd0, got}, 32'h0000007C);

    repeat (4) @(negedge clk_32f);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
- Final transmit stage of the PHY lane. Sits directly downstream of the 2:1 byte mux that runs at clk_4f.
- Takes one byte per 8 serial clocks and shifts it out MSB-first on a 1-bit serial line.
- After reset it first sends a comma training sequence (COM 0xBC). It then sends payload bytes, or the IDLE symbol 0x7C whenever no valid byte is offered.
- Asserts load_tick so the upstream stage knows exactly when its byte is consumed.

Parameters:
- SYNC_BYTES, 4: number of COM bytes sent after reset before payload is accepted.
- COM_SYM, 8'hBC: comma/training symbol.
- IDLE_SYM, 8'h7C: idle filler symbol.
- COM_PERIOD, 16: consecutive idle bytes after which one COM is forced (optional feature only).

Ports:
- clk_32f  in  1  serial bit clock; the only clock in the block.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk_32f.
- data_in  in  8  byte from the upstream mux.
- valid_in  in  1  data_in holds a payload byte.
- data_out  out  1  serial bit; equals shreg[7].
- load_tick  out  1  high in the cycle before a byte-load edge while in ACTIVE.
- active  out  1  high once training is complete (state ACTIVE).

Behaviour:
- Clock and reset: one clock, clk_32f. reset is synchronous and active-low. All state changes happen on the rising edge of clk_32f.
- Values while reset=0:
  - bit_cnt=7, shreg=8'h00, state=SYNC, sync_cnt=0.
  - Resulting outputs: data_out=0, load_tick=0, active=0.
- bit_cnt (3 bit):
  - Increments every edge and wraps 7->0.
  - Starting from bit_cnt=7 means the first edge after reset release is a load edge.
- Load edge (bit_cnt==7): shreg <= next_byte.
- All other edges: shreg <= {shreg[6:0],1'b0}.
- Each byte therefore occupies exactly 8 cycles on data_out, MSB first. Bit 7 appears in the cycle immediately after the load edge.
- Latency: data_in sampled at a load edge has its bit 7 on data_out one cycle later and bit 0 eight cycles later.
- State SYNC:
  - next_byte=COM_SYM; valid_in and data_in are ignored.
  - sync_cnt increments on each load edge.
  - On the load edge where sync_cnt==SYNC_BYTES-1, go to ACTIVE.
  - load_tick=0, active=0.
- State ACTIVE:
  - next_byte = valid_in ? data_in : IDLE_SYM.
  - load_tick = (bit_cnt==7). The upstream stage must hold data_in/valid_in stable while load_tick is high; the byte is consumed on that edge.
  - active=1. There is no exit from ACTIVE except reset.
- sync_cnt width: $clog2(SYNC_BYTES)+1.
- Handshake: valid_in with load_tick=0 is not consumed and has no effect. Upstream keeps the byte until it sees load_tick.
- Reset mid-byte: the partial byte is discarded. data_out drops to 0 on the reset edge. After release the block re-enters SYNC and resends SYNC_BYTES COM bytes.
- SYNC_BYTES=1 is legal: the first byte after reset is COM, then ACTIVE.

Optional Feature:
- Macro: PS_COM_INSERT_EN.
- When defined:
  - An idle run counter (width $clog2(COM_PERIOD)+1) increments on each ACTIVE load edge that loads IDLE_SYM.
  - When the counter reaches COM_PERIOD-1 and valid_in=0, COM_SYM is loaded instead of IDLE_SYM and the counter clears.
  - A valid byte always wins and also clears the counter.
  - load_tick behaviour is unchanged.
- When undefined: the counter is absent, and ACTIVE idles are always IDLE_SYM.

Decomposition:
- Shared package (phy_pkg) holds:
  - COM_SYM, IDLE_SYM defaults.
  - State encoding: SYNC=1'b0, ACTIVE=1'b1.
- Natural sub-module: ps_shift8, containing bit_cnt, shreg, load_tick generation and data_out.
- Parent block holds the SYNC/ACTIVE FSM, next_byte selection and the optional idle counter.
- The design is to be synthesized with the same cmos cell flow as the other stages. The synth_paralelo_serial_tx netlist is compared against RTL in the bench.

Test Plan:
- Reset held low for 10 cycles -> data_out=0, load_tick=0, active=0 throughout.
- Release reset with SYNC_BYTES=4 -> 32 serial bits of 10111100 repeated 4 times. active rises on the 4th load edge; first load_tick is 32 cycles after the first load edge.
- ACTIVE, valid_in=1, data_in=8'hA5 at load_tick -> next 8 bits 1,0,1,0,0,1,0,1. The next byte with valid_in=0 -> 01111100.
- valid_in=1 asserted mid-byte then dropped before load_tick -> no effect; IDLE 0x7C is sent.
- Reset asserted at bit_cnt=3 during byte 8'hFF -> data_out=0 on the next edge; after release a full COM training sequence is sent again.
- PS_COM_INSERT_EN defined, COM_PERIOD=16, valid_in=0 -> 15 bytes of 0x7C then one 0xBC, repeating. Injecting 0x3C at byte 10 clears the run, so the next COM arrives 16 bytes later. RTL and synth outputs match bit-for-bit.
